escalonador_busca: RTL and testbench
====================================

ESCALONADOR_BUSCA -- requirements
Module: escalonador_busca

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, meaning node address width.
REQ-002 The block SHALL have parameter DISTANCIA_WIDTH, default 16, meaning path cost width.
REQ-003 The block SHALL have parameter FILA_PROF, default 4 (power of 2), meaning request FIFO depth.
REQ-004 The block SHALL have parameter TIMEOUT_CICLOS, default 500000, meaning the search watchdog limit in cycles.
REQ-005 The block SHALL have these ports, in this order:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_in  in  1  request offered
- req_ready_out  out  1  request accepted when high with req_valid_in
- req_fonte_in  in  ADDR_WIDTH  source node
- req_destino_in  in  ADDR_WIDTH  destination node
- core_addr_fonte_out  out  ADDR_WIDTH  source to search core
- core_addr_destino_out  out  ADDR_WIDTH  destination to search core
- core_wr_fonte_out  out  1  one-cycle start pulse to core
- core_distancia_valid_in  in  1  destination distance established
- core_distancia_in  in  DISTANCIA_WIDTH  destination distance
- core_caminho_valid_in  in  1  one path node emitted by core
- core_pronto_in  in  1  path generation finished
- res_valid_out  out  1  result available
- res_ready_in  in  1  result consumed
- res_fonte_out, res_destino_out  out  ADDR_WIDTH  echoed request
- res_distancia_out  out  DISTANCIA_WIDTH  path cost
- res_tamanho_out  out  ADDR_WIDTH+1  number of path nodes
- res_timeout_out  out  1  search aborted by watchdog
- ocupado_out  out  1  state not OCIOSO
- pendentes_out  out  $clog2(FILA_PROF)+1  FIFO occupancy

Function
REQ-006 FIFO SHALL accept a request on clk when req_valid_in && req_ready_out; req_ready_out = (occupancy < FILA_PROF), combinational.
REQ-007 Simultaneous push and pop SHALL leave occupancy unchanged; push when full SHALL be dropped without state change; pointers SHALL wrap modulo FILA_PROF.
REQ-008 FSM states SHALL be OCIOSO, DISPARO, AGUARDA, RESULTADO.
REQ-009 OCIOSO: if FIFO non-empty, pop head, latch fonte/destino, go to DISPARO next cycle.
REQ-010 DISPARO (exactly 1 cycle): core_wr_fonte_out=1, core_addr_* = latched values; clear timer, distance, tamanho; go to AGUARDA. core_addr_* SHALL be 0 outside DISPARO.
REQ-011 If latched fonte == destino, DISPARO SHALL emit no core pulse and go directly to RESULTADO with distancia=0, tamanho=1, timeout=0.
REQ-012 AGUARDA: core_distancia_valid_in SHALL latch core_distancia_in (last write wins); each core_caminho_valid_in SHALL increment tamanho, saturating at all-ones.
REQ-013 AGUARDA: core_pronto_in SHALL move to RESULTADO with timeout=0; caminho_valid in the same cycle SHALL still be counted.
REQ-014 AGUARDA: when timer reaches TIMEOUT_CICLOS-1 without pronto, SHALL move to RESULTADO with timeout=1, distancia all-ones, tamanho 0; pronto in that same cycle SHALL take priority (timeout=0).
REQ-015 RESULTADO: res_valid_out=1 with stable res_* until res_ready_in; on handshake go to OCIOSO (next pop no earlier than the following cycle).
REQ-016 Core inputs SHALL be ignored in OCIOSO, DISPARO and RESULTADO.
REQ-017 Latency: accepted request into empty idle block SHALL produce core_wr_fonte_out 2 cycles after acceptance edge.

Reset
REQ-018 rst_n low SHALL asynchronously force state OCIOSO, FIFO empty, timer 0, all outputs 0 except req_ready_out=1 and pendentes_out=0.
REQ-019 Reset mid-search SHALL discard queued and in-flight requests; no result SHALL be emitted for them.

Structure
REQ-020 Package escalonador_pkg SHALL hold the state enum and default parameter constants.
REQ-021 FIFO SHALL be sub-module fila_requisicoes (data width 2*ADDR_WIDTH, depth FILA_PROF).

Verification
REQ-022 Single request fonte=5, destino=182; core returns distancia=37, 9 caminho pulses, pronto -> one wr pulse, result distancia=37, tamanho=9, timeout=0.
REQ-023 Push 5 requests back-to-back, core idle -> 4 accepted, req_ready_out low on 5th, pendentes_out=3 after first pop.
REQ-024 fonte=destino=20 -> no core_wr_fonte_out pulse, result distancia=0, tamanho=1.
REQ-025 TIMEOUT_CICLOS=100, core never pronto -> res_timeout_out=1 exactly 100 cycles after AGUARDA entry, distancia=all-ones.
REQ-026 res_ready_in held low 50 cycles with 2 queued -> res_* stable, no new wr pulse until handshake.
REQ-027 rst_n asserted in AGUARDA with 2 queued -> outputs reset asynchronously, no result after release, pendentes_out=0.

Source files
------------

// File: rtl/escalonador_pkg.sv
// +--------------------------------------------------------------------+
// | escalonador_pkg: shared FSM state type and default sizes (rev 1.0) |
// +--------------------------------------------------------------------+
`default_nettype none

package escalonador_pkg;

  localparam int ADDR_WIDTH_DEF      = 12;
  localparam int DISTANCIA_WIDTH_DEF = 16;
  localparam int FILA_PROF_DEF       = 4;
  localparam int TIMEOUT_CICLOS_DEF  = 500000;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    DISPARO   = 2'd1,
    AGUARDA   = 2'd2,
    RESULTADO = 2'd3
  } estado_t;

endpackage

`default_nettype wire

// File: rtl/fila_requisicoes.sv
// +--------------------------------------------------------------------+
// | fila_requisicoes: circular request FIFO, power-of-2 depth (rev 1.0)|
// +--------------------------------------------------------------------+
`default_nettype none

module fila_requisicoes #(
  parameter int DATA_WIDTH = 24,
  parameter int PROF       = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_in,
  input  logic [DATA_WIDTH-1:0]   dado_in,
  input  logic                    pop_in,
  output logic [DATA_WIDTH-1:0]   dado_out,
  output logic [$clog2(PROF):0]   ocupacao_out,
  output logic                    livre_out
);

  localparam int PW = $clog2(PROF);
  localparam logic [PW:0] PROF_CNT = (PW+1)'(PROF);

  logic [DATA_WIDTH-1:0] mem_q [PROF];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic                  push_ok, pop_ok;

  // Pointers are exactly PW bits wide, so the increment wraps modulo PROF.
  always_comb begin
    push_ok  = push_in && (count_q < PROF_CNT);
    pop_ok   = pop_in && (count_q != '0);
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= dado_in;
  end

  assign dado_out     = mem_q[rd_ptr_q];
  assign ocupacao_out = count_q;
  assign livre_out    = (count_q < PROF_CNT);

endmodule

`default_nettype wire

// File: rtl/escalonador_busca.sv
// +--------------------------------------------------------------------+
// | escalonador_busca: queues path searches and sequences the core     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module escalonador_busca
  import escalonador_pkg::*;
#(
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int DISTANCIA_WIDTH = DISTANCIA_WIDTH_DEF,
  parameter int FILA_PROF       = FILA_PROF_DEF,
  parameter int TIMEOUT_CICLOS  = TIMEOUT_CICLOS_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid_in,
  output logic                         req_ready_out,
  input  logic [ADDR_WIDTH-1:0]        req_fonte_in,
  input  logic [ADDR_WIDTH-1:0]        req_destino_in,
  output logic [ADDR_WIDTH-1:0]        core_addr_fonte_out,
  output logic [ADDR_WIDTH-1:0]        core_addr_destino_out,
  output logic                         core_wr_fonte_out,
  input  logic                         core_distancia_valid_in,
  input  logic [DISTANCIA_WIDTH-1:0]   core_distancia_in,
  input  logic                         core_caminho_valid_in,
  input  logic                         core_pronto_in,
  output logic                         res_valid_out,
  input  logic                         res_ready_in,
  output logic [ADDR_WIDTH-1:0]        res_fonte_out,
  output logic [ADDR_WIDTH-1:0]        res_destino_out,
  output logic [DISTANCIA_WIDTH-1:0]   res_distancia_out,
  output logic [ADDR_WIDTH:0]          res_tamanho_out,
  output logic                         res_timeout_out,
  output logic                         ocupado_out,
  output logic [$clog2(FILA_PROF):0]   pendentes_out
);

  localparam int TW = $clog2(TIMEOUT_CICLOS) + 1;
  localparam logic [TW-1:0] TIMER_FIM = TW'(TIMEOUT_CICLOS - 1);
  localparam int DW = 2 * ADDR_WIDTH;

  estado_t                      estado_q, estado_d;
  logic [ADDR_WIDTH-1:0]        fonte_q, fonte_d;
  logic [ADDR_WIDTH-1:0]        destino_q, destino_d;
  logic [DISTANCIA_WIDTH-1:0]   distancia_q, distancia_d;
  logic [ADDR_WIDTH:0]          tamanho_q, tamanho_d;
  logic                         timeout_q, timeout_d;
  logic [TW-1:0]                timer_q, timer_d;

  logic                         fila_pop;
  logic [DW-1:0]                fila_dado;
  logic [$clog2(FILA_PROF):0]   fila_ocup;
  logic                         fila_vazia;
  logic                         mesmo_no;

  fila_requisicoes #(
    .DATA_WIDTH (DW),
    .PROF       (FILA_PROF)
  ) u_fila (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_in      (req_valid_in),
    .dado_in      ({req_fonte_in, req_destino_in}),
    .pop_in       (fila_pop),
    .dado_out     (fila_dado),
    .ocupacao_out (fila_ocup),
    .livre_out    (req_ready_out)
  );

  assign fila_vazia = (fila_ocup == '0);
  assign mesmo_no   = (fonte_q == destino_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= OCIOSO;
      fonte_q     <= '0;
      destino_q   <= '0;
      distancia_q <= '0;
      tamanho_q   <= '0;
      timeout_q   <= 1'b0;
      timer_q     <= '0;
    end else begin
      estado_q    <= estado_d;
      fonte_q     <= fonte_d;
      destino_q   <= destino_d;
      distancia_q <= distancia_d;
      tamanho_q   <= tamanho_d;
      timeout_q   <= timeout_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    estado_d    = estado_q;
    fonte_d     = fonte_q;
    destino_d   = destino_q;
    distancia_d = distancia_q;
    tamanho_d   = tamanho_q;
    timeout_d   = timeout_q;
    timer_d     = timer_q;
    case (estado_q)
      OCIOSO: begin
        if (!fila_vazia) begin
          fonte_d   = fila_dado[DW-1 -: ADDR_WIDTH];
          destino_d = fila_dado[ADDR_WIDTH-1:0];
          estado_d  = DISPARO;
        end
      end
      DISPARO: begin
        timer_d     = '0;
        timeout_d   = 1'b0;
        distancia_d = '0;
        if (mesmo_no) begin
          tamanho_d = (ADDR_WIDTH+1)'(1);
          estado_d  = RESULTADO;
        end else begin
          tamanho_d = '0;
          estado_d  = AGUARDA;
        end
      end
      AGUARDA: begin
        timer_d = timer_q + TW'(1);
        if (core_distancia_valid_in) distancia_d = core_distancia_in;
        if (core_caminho_valid_in && (tamanho_q != '1))
          tamanho_d = tamanho_q + (ADDR_WIDTH+1)'(1);
        // pronto wins over a watchdog expiry landing in the same cycle
        if (core_pronto_in) begin
          timeout_d = 1'b0;
          estado_d  = RESULTADO;
        end else if (timer_q == TIMER_FIM) begin
          timeout_d   = 1'b1;
          distancia_d = '1;
          tamanho_d   = '0;
          estado_d    = RESULTADO;
        end
      end
      RESULTADO: begin
        if (res_ready_in) estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_comb begin
    fila_pop              = 1'b0;
    core_wr_fonte_out     = 1'b0;
    core_addr_fonte_out   = '0;
    core_addr_destino_out = '0;
    res_valid_out         = 1'b0;
    case (estado_q)
      OCIOSO:    fila_pop = !fila_vazia;
      DISPARO: begin
        core_addr_fonte_out   = fonte_q;
        core_addr_destino_out = destino_q;
        core_wr_fonte_out     = !mesmo_no;
      end
      RESULTADO: res_valid_out = 1'b1;
      default:   fila_pop = 1'b0;
    endcase
  end

  assign ocupado_out       = (estado_q != OCIOSO);
  assign pendentes_out     = fila_ocup;
  assign res_fonte_out     = fonte_q;
  assign res_destino_out   = destino_q;
  assign res_distancia_out = distancia_q;
  assign res_tamanho_out   = tamanho_q;
  assign res_timeout_out   = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_escalonador_busca.sv
// Directed bench for escalonador_busca: each task drives one scenario and checks inline.
`default_nettype none

module tb_escalonador_busca;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int FP = 4;
  localparam int TO = 100;
  localparam int CW = $clog2(FP) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid_in = 1'b0;
  logic          req_ready_out;
  logic [AW-1:0] req_fonte_in = '0;
  logic [AW-1:0] req_destino_in = '0;
  logic [AW-1:0] core_addr_fonte_out;
  logic [AW-1:0] core_addr_destino_out;
  logic          core_wr_fonte_out;
  logic          core_distancia_valid_in = 1'b0;
  logic [DW-1:0] core_distancia_in = '0;
  logic          core_caminho_valid_in = 1'b0;
  logic          core_pronto_in = 1'b0;
  logic          res_valid_out;
  logic          res_ready_in = 1'b0;
  logic [AW-1:0] res_fonte_out;
  logic [AW-1:0] res_destino_out;
  logic [DW-1:0] res_distancia_out;
  logic [AW:0]   res_tamanho_out;
  logic          res_timeout_out;
  logic          ocupado_out;
  logic [CW-1:0] pendentes_out;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int res_count = 0;

  escalonador_busca #(
    .ADDR_WIDTH      (AW),
    .DISTANCIA_WIDTH (DW),
    .FILA_PROF       (FP),
    .TIMEOUT_CICLOS  (TO)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .req_valid_in            (req_valid_in),
    .req_ready_out           (req_ready_out),
    .req_fonte_in            (req_fonte_in),
    .req_destino_in          (req_destino_in),
    .core_addr_fonte_out     (core_addr_fonte_out),
    .core_addr_destino_out   (core_addr_destino_out),
    .core_wr_fonte_out       (core_wr_fonte_out),
    .core_distancia_valid_in (core_distancia_valid_in),
    .core_distancia_in       (core_distancia_in),
    .core_caminho_valid_in   (core_caminho_valid_in),
    .core_pronto_in          (core_pronto_in),
    .res_valid_out           (res_valid_out),
    .res_ready_in            (res_ready_in),
    .res_fonte_out           (res_fonte_out),
    .res_destino_out         (res_destino_out),
    .res_distancia_out       (res_distancia_out),
    .res_tamanho_out         (res_tamanho_out),
    .res_timeout_out         (res_timeout_out),
    .ocupado_out             (ocupado_out),
    .pendentes_out           (pendentes_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (core_wr_fonte_out === 1'b1) wr_count++;
    if (res_valid_out === 1'b1) res_count++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid_in = 1'b0;
    core_distancia_valid_in = 1'b0;
    core_caminho_valid_in = 1'b0;
    core_pronto_in = 1'b0;
    res_ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic push3(input int base);
    for (int i = 0; i < 3; i++) begin
      req_valid_in = 1'b1;
      req_fonte_in = AW'(base + 2 * i);
      req_destino_in = AW'(base + 2 * i + 1);
      step();
    end
    req_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (req_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready_out); end
    checks++; if (pendentes_out !== 3'd0) begin errors++; $display("FAIL reset_pendentes got %0d exp 0", pendentes_out); end
    checks++; if (ocupado_out !== 1'b0) begin errors++; $display("FAIL reset_ocupado got %b exp 0", ocupado_out); end
    checks++; if (res_valid_out !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", res_valid_out); end
    checks++; if (core_wr_fonte_out !== 1'b0) begin errors++; $display("FAIL reset_wr got %b exp 0", core_wr_fonte_out); end
    checks++; if (core_addr_fonte_out !== 12'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", core_addr_fonte_out); end
    checks++; if (res_distancia_out !== 16'd0) begin errors++; $display("FAIL reset_dist got %0d exp 0", res_distancia_out); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    int wc0;
    wc0 = wr_count;
    req_valid_in = 1'b1; req_fonte_in = 12'd5; req_destino_in = 12'd182;
    step();
    req_valid_in = 1'b0;
    checks++; if (core_wr_fonte_out !== 1'b0) begin errors++; $display("FAIL single_wr_early got %b exp 0", core_wr_fonte_out); end
    checks++; if (pendentes_out !== 3'd1) begin errors++; $display("FAIL single_pend got %0d exp 1", pendentes_out); end
    step();
    checks++; if (core_wr_fonte_out !== 1'b1) begin errors++; $display("FAIL single_wr_pulse got %b exp 1", core_wr_fonte_out); end
    checks++; if (core_addr_fonte_out !== 12'd5 || core_addr_destino_out !== 12'd182) begin
      errors++; $display("FAIL single_core_addr got %0d/%0d exp 5/182", core_addr_fonte_out, core_addr_destino_out); end
    step();
    checks++; if (core_wr_fonte_out !== 1'b0 || core_addr_fonte_out !== 12'd0) begin
      errors++; $display("FAIL single_wr_end got wr=%b addr=%0d exp 0/0", core_wr_fonte_out, core_addr_fonte_out); end
    core_distancia_valid_in = 1'b1; core_distancia_in = 16'd99;
    step();
    core_distancia_in = 16'd37;
    step();
    core_distancia_valid_in = 1'b0;
    core_caminho_valid_in = 1'b1;
    repeat (8) step();
    core_pronto_in = 1'b1;
    step();
    core_pronto_in = 1'b0; core_caminho_valid_in = 1'b0;
    checks++; if (res_valid_out !== 1'b1) begin errors++; $display("FAIL single_res_valid got %b exp 1", res_valid_out); end
    checks++; if (res_distancia_out !== 16'd37) begin errors++; $display("FAIL single_dist got %0d exp 37", res_distancia_out); end
    checks++; if (res_tamanho_out !== 13'd9) begin errors++; $display("FAIL single_tamanho got %0d exp 9", res_tamanho_out); end
    checks++; if (res_timeout_out !== 1'b0) begin errors++; $display("FAIL single_timeout got %b exp 0", res_timeout_out); end
    checks++; if (res_fonte_out !== 12'd5 || res_destino_out !== 12'd182) begin
      errors++; $display("FAIL single_echo got %0d/%0d exp 5/182", res_fonte_out, res_destino_out); end
    checks++; if (wr_count !== wc0 + 1) begin errors++; $display("FAIL single_wr_count got %0d exp %0d", wr_count - wc0, 1); end
    res_ready_in = 1'b1;
    step();
    res_ready_in = 1'b0;
    checks++; if (res_valid_out !== 1'b0 || ocupado_out !== 1'b0) begin
      errors++; $display("FAIL single_handshake got valid=%b ocup=%b exp 0/0", res_valid_out, ocupado_out); end
  endtask

  task automatic test_same_node();
    int wc0;
    wc0 = wr_count;
    req_valid_in = 1'b1; req_fonte_in = 12'd20; req_destino_in = 12'd20;
    step();
    req_valid_in = 1'b0;
    step();
    checks++; if (core_wr_fonte_out !== 1'b0) begin errors++; $display("FAIL same_wr got %b exp 0", core_wr_fonte_out); end
    step();
    checks++; if (res_valid_out !== 1'b1) begin errors++; $display("FAIL same_res_valid got %b exp 1", res_valid_out); end
    checks++; if (res_distancia_out !== 16'd0 || res_tamanho_out !== 13'd1 || res_timeout_out !== 1'b0) begin
      errors++; $display("FAIL same_result got d=%0d t=%0d to=%b exp 0/1/0", res_distancia_out, res_tamanho_out, res_timeout_out); end
    checks++; if (wr_count !== wc0) begin errors++; $display("FAIL same_wr_count got %0d exp 0", wr_count - wc0); end
    res_ready_in = 1'b1;
    step();
    res_ready_in = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    req_valid_in = 1'b1; req_fonte_in = 12'd1; req_destino_in = 12'd2;
    step();
    req_valid_in = 1'b0;
    step();
    step();
    core_caminho_valid_in = 1'b1;
    step();
    core_caminho_valid_in = 1'b0;
    n = 1;
    while (res_valid_out !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++; if (n !== 100) begin errors++; $display("FAIL timeout_latency got %0d exp 100", n); end
    checks++; if (res_timeout_out !== 1'b1) begin errors++; $display("FAIL timeout_flag got %b exp 1", res_timeout_out); end
    checks++; if (res_distancia_out !== 16'hFFFF) begin errors++; $display("FAIL timeout_dist got %h exp ffff", res_distancia_out); end
    checks++; if (res_tamanho_out !== 13'd0) begin errors++; $display("FAIL timeout_tamanho got %0d exp 0", res_tamanho_out); end
    res_ready_in = 1'b1;
    step();
    res_ready_in = 1'b0;
  endtask

  task automatic test_fifo_full();
    apply_reset();
    req_valid_in = 1'b1; req_fonte_in = 12'd3; req_destino_in = 12'd4;
    step();
    req_valid_in = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      req_valid_in = 1'b1;
      req_fonte_in = AW'(10 + i);
      req_destino_in = AW'(40 + i);
      checks++; if (req_ready_out !== (i < 4 ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL full_ready_%0d got %b exp %b", i, req_ready_out, (i < 4 ? 1'b1 : 1'b0)); end
      step();
    end
    req_valid_in = 1'b0;
    checks++; if (pendentes_out !== 3'd4) begin errors++; $display("FAIL full_pend got %0d exp 4", pendentes_out); end
    core_pronto_in = 1'b1;
    step();
    core_pronto_in = 1'b0;
    res_ready_in = 1'b1;
    step();
    res_ready_in = 1'b0;
    step();
    checks++; if (pendentes_out !== 3'd3) begin errors++; $display("FAIL full_pend_pop got %0d exp 3", pendentes_out); end
    checks++; if (core_addr_fonte_out !== 12'd10 || core_wr_fonte_out !== 1'b1) begin
      errors++; $display("FAIL full_head got addr=%0d wr=%b exp 10/1", core_addr_fonte_out, core_wr_fonte_out); end
  endtask

  task automatic test_hold();
    int wc0;
    int bad;
    apply_reset();
    push3(7);
    checks++; if (pendentes_out !== 3'd2) begin errors++; $display("FAIL hold_pend got %0d exp 2", pendentes_out); end
    core_distancia_valid_in = 1'b1; core_distancia_in = 16'd55; core_pronto_in = 1'b1;
    step();
    core_distancia_valid_in = 1'b0; core_pronto_in = 1'b0;
    wc0 = wr_count;
    bad = 0;
    repeat (50) begin
      if (res_valid_out !== 1'b1 || res_distancia_out !== 16'd55 || res_fonte_out !== 12'd7 ||
          res_destino_out !== 12'd8 || res_tamanho_out !== 13'd0 || core_wr_fonte_out !== 1'b0) bad++;
      step();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles exp 0", bad); end
    checks++; if (wr_count !== wc0) begin errors++; $display("FAIL hold_no_wr got %0d exp 0", wr_count - wc0); end
    res_ready_in = 1'b1;
    step();
    res_ready_in = 1'b0;
    step();
    checks++; if (core_wr_fonte_out !== 1'b1 || core_addr_fonte_out !== 12'd9) begin
      errors++; $display("FAIL hold_next got wr=%b addr=%0d exp 1/9", core_wr_fonte_out, core_addr_fonte_out); end
  endtask

  task automatic test_reset_mid();
    int res0;
    apply_reset();
    push3(21);
    res0 = res_count;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (pendentes_out !== 3'd0) begin errors++; $display("FAIL mid_pend got %0d exp 0", pendentes_out); end
    checks++; if (ocupado_out !== 1'b0) begin errors++; $display("FAIL mid_ocupado got %b exp 0", ocupado_out); end
    checks++; if (req_ready_out !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", req_ready_out); end
    checks++; if (res_valid_out !== 1'b0 || core_wr_fonte_out !== 1'b0) begin
      errors++; $display("FAIL mid_outputs got valid=%b wr=%b exp 0/0", res_valid_out, core_wr_fonte_out); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    core_pronto_in = 1'b1;
    step();
    core_pronto_in = 1'b0;
    repeat (20) step();
    checks++; if (res_count !== res0) begin errors++; $display("FAIL mid_no_result got %0d exp 0", res_count - res0); end
    checks++; if (pendentes_out !== 3'd0) begin errors++; $display("FAIL mid_pend_after got %0d exp 0", pendentes_out); end
    checks++; if (ocupado_out !== 1'b0) begin errors++; $display("FAIL mid_idle_after got %b exp 0", ocupado_out); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_node();
    test_timeout();
    test_fifo_full();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
